// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM controller: register map, CTRL/BLINK field
// positions and the byte-lane mask helper.
package led_pwm_pkg;

   typedef enum logic [2:0] {
      REG_CTRL     = 3'd0,
      REG_PRESCALE = 3'd1,
      REG_BLINK    = 3'd2,
      REG_RSVD     = 3'd3,
      REG_DUTY0    = 3'd4
   } reg_idx_e;

   localparam int CTRL_EN_BIT      = 0;
   localparam int CTRL_INV_BIT     = 1;
   localparam int CTRL_CLR_BIT     = 2;
   localparam int PRESCALE_W       = 16;
   localparam int BLINK_PERIOD_LSB = 16;
   localparam int BLINK_PERIOD_W   = 8;

   // Expands the four byte selects into a 32-bit bit-enable mask.
   function automatic logic [31:0] lane_mask(input logic [3:0] sel);
      for (int b = 0; b < 4; b++) lane_mask[b*8 +: 8] = {8{sel[b]}};
   endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: bus-visible shadow duty, boundary-loaded active duty,
// PWM compare and registered output with blank/invert gating.
module led_pwm_channel
   import led_pwm_pkg::*;
#(
   parameter int PwmWidth = 8
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                duty_we,
   input  logic [PwmWidth-1:0] duty_wdata,
   input  logic                load,
   input  logic                en,
   input  logic                invert,
   input  logic                blank,
   input  logic [PwmWidth-1:0] cnt,
   output logic [PwmWidth-1:0] shadow,
   output logic                led
);

   logic [PwmWidth-1:0] shadow_next;
   logic [PwmWidth-1:0] active;

   // A write landing on the reload edge must be the value that gets loaded.
   assign shadow_next = duty_we ? duty_wdata : shadow;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         shadow <= '0;
         active <= '0;
         led    <= 1'b0;
      end else begin
         shadow <= shadow_next;
         if (load) active <= shadow_next;
         led <= (en & (cnt < active) & ~blank) ^ invert;
      end
   end

endmodule

// File: rtl/led_pwm_controller.sv
// Wishbone-pipelined LED PWM controller. Per-channel blinking is compiled in
// only when LED_PWM_BLINK_EN is defined.
module led_pwm_controller
   import led_pwm_pkg::*;
#(
   parameter int NumLeds   = 4,
   parameter int PwmWidth  = 8,
   parameter int DataWidth = 32,
   parameter int AddrWidth = 30,
   parameter int SelWidth  = DataWidth / 8
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic [DataWidth-1:0] wb_data_i,
   input  logic [AddrWidth-1:0] wb_addr_i,
   input  logic [SelWidth-1:0]  wb_sel_i,
   input  logic                 wb_cyc_i,
   input  logic                 wb_stb_i,
   input  logic                 wb_we_i,
   output logic [DataWidth-1:0] wb_data_o,
   output logic                 wb_ack_o,
   output logic                 wb_err_o,
   output logic                 wb_stall_o,
   output logic [NumLeds-1:0]   leds_o
);

   localparam logic [PwmWidth-1:0] PwmMax = {{(PwmWidth-1){1'b1}}, 1'b0};

   logic                    req, addr_ok, wr, sync_clr;
   logic                    ctrl_hit, psc_hit, blink_hit;
   logic [NumLeds-1:0]      duty_hit;
   logic [31:0]             lane;
   logic [DataWidth-1:0]    rdata;
   logic                    en, invert;
   logic [PRESCALE_W-1:0]   prescale, psc_cnt;
   logic [PwmWidth-1:0]     pwm_cnt;
   logic                    tick, period_end, load;
   logic [NumLeds-1:0]      blank;
   logic [PwmWidth-1:0]     shadow     [NumLeds];
   logic [PwmWidth-1:0]     duty_wdata [NumLeds];
   logic                    unused_bits;

   assign wb_stall_o  = 1'b0;
   assign unused_bits = ^{wb_data_i, lane};

   always_comb begin
      req       = wb_cyc_i & wb_stb_i;
      ctrl_hit  = wb_addr_i == AddrWidth'(REG_CTRL);
      psc_hit   = wb_addr_i == AddrWidth'(REG_PRESCALE);
      blink_hit = wb_addr_i == AddrWidth'(REG_BLINK);
      for (int i = 0; i < NumLeds; i++)
         duty_hit[i] = wb_addr_i == AddrWidth'(int'(REG_DUTY0) + i);
      addr_ok  = ctrl_hit | psc_hit | blink_hit | (|duty_hit);
      wr       = req & wb_we_i & addr_ok;
      lane     = lane_mask(wb_sel_i);
      sync_clr = wr & ctrl_hit & wb_sel_i[0] & wb_data_i[CTRL_CLR_BIT];
   end

   // Prescaler compare is >= so shrinking P below the running count ticks at once.
   assign tick       = en & (psc_cnt >= prescale);
   assign period_end = tick & (pwm_cnt == PwmMax);
   assign load       = period_end | ~en | sync_clr;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         psc_cnt <= '0;
         pwm_cnt <= '0;
      end else if (!en || sync_clr) begin
         psc_cnt <= '0;
         pwm_cnt <= '0;
      end else if (tick) begin
         psc_cnt <= '0;
         pwm_cnt <= (pwm_cnt == PwmMax) ? '0 : pwm_cnt + 1'b1;
      end else begin
         psc_cnt <= psc_cnt + 1'b1;
      end
   end

`ifdef LED_PWM_BLINK_EN
   logic [NumLeds-1:0]        blink_mask;
   logic [BLINK_PERIOD_W-1:0] blink_period, blink_cnt;
   logic                      phase;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         blink_mask   <= '0;
         blink_period <= '0;
         blink_cnt    <= '0;
         phase        <= 1'b0;
      end else begin
         if (wr && blink_hit) begin
            blink_mask   <= (blink_mask & ~lane[NumLeds-1:0])
                          | (wb_data_i[NumLeds-1:0] & lane[NumLeds-1:0]);
            blink_period <= (blink_period & ~lane[BLINK_PERIOD_LSB +: BLINK_PERIOD_W])
                          | (wb_data_i[BLINK_PERIOD_LSB +: BLINK_PERIOD_W]
                             & lane[BLINK_PERIOD_LSB +: BLINK_PERIOD_W]);
         end
         if (!en || sync_clr) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
         end else if (period_end) begin
            if (blink_cnt >= blink_period) begin
               blink_cnt <= '0;
               phase     <= ~phase;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

   assign blank = {NumLeds{phase}} & blink_mask;
`else
   assign blank = '0;
`endif

   for (genvar i = 0; i < NumLeds; i++) begin : g_ch
      assign duty_wdata[i] = (shadow[i] & ~lane[PwmWidth-1:0])
                           | (wb_data_i[PwmWidth-1:0] & lane[PwmWidth-1:0]);
      led_pwm_channel #(.PwmWidth(PwmWidth)) u_ch (
         .clk_i      (clk_i),
         .reset_i    (reset_i),
         .duty_we    (wr & duty_hit[i]),
         .duty_wdata (duty_wdata[i]),
         .load       (load),
         .en         (en),
         .invert     (invert),
         .blank      (blank[i]),
         .cnt        (pwm_cnt),
         .shadow     (shadow[i]),
         .led        (leds_o[i])
      );
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      rdata = '0;
      if (ctrl_hit) begin
         rdata[CTRL_EN_BIT]  = en;
         rdata[CTRL_INV_BIT] = invert;
      end
      if (psc_hit) rdata[PRESCALE_W-1:0] = prescale;
`ifdef LED_PWM_BLINK_EN
      if (blink_hit) begin
         rdata[NumLeds-1:0]                          = blink_mask;
         rdata[BLINK_PERIOD_LSB +: BLINK_PERIOD_W]   = blink_period;
      end
`endif
      for (int i = 0; i < NumLeds; i++)
         if (duty_hit[i]) rdata[PwmWidth-1:0] = shadow[i];
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wb_ack_o  <= 1'b0;
         wb_err_o  <= 1'b0;
         wb_data_o <= '0;
         en        <= 1'b0;
         invert    <= 1'b0;
         prescale  <= '0;
      end else begin
         wb_ack_o  <= req & addr_ok;
         wb_err_o  <= req & ~addr_ok;
         wb_data_o <= (req && addr_ok && !wb_we_i) ? rdata : '0;
         if (wr && ctrl_hit && wb_sel_i[0]) begin
            en     <= wb_data_i[CTRL_EN_BIT];
            invert <= wb_data_i[CTRL_INV_BIT];
         end
         if (wr && psc_hit)
            prescale <= (prescale & ~lane[PRESCALE_W-1:0])
                      | (wb_data_i[PRESCALE_W-1:0] & lane[PRESCALE_W-1:0]);
      end
   end

endmodule

// File: tb/tb_led_pwm_controller.sv
// Self-checking bench for led_pwm_controller (4 channels, 8-bit PWM). Blink
// scenarios are exercised when LED_PWM_BLINK_EN is defined.
module tb_led_pwm_controller;

   localparam int NL = 4;
   localparam int PERIOD = 255;   // PWM period in ticks for 8-bit counters
`ifdef LED_PWM_BLINK_EN
   localparam logic [31:0] BLINK_RB = 32'h00FF_000F;
`else
   localparam logic [31:0] BLINK_RB = 32'h0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [31:0]   wb_wdata = '0;
   logic [29:0]   wb_addr = '0;
   logic [3:0]    wb_sel = '0;
   logic          wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
   logic [31:0]   wb_rdata;
   logic          wb_ack, wb_err, wb_stall;
   logic [NL-1:0] leds;

   int checks = 0;
   int failures = 0;
   int duty_r [NL];

   always #5 clk = ~clk;

   led_pwm_controller #(.NumLeds(NL), .PwmWidth(8)) dut (
      .clk_i      (clk),
      .reset_i    (reset),
      .wb_data_i  (wb_wdata),
      .wb_addr_i  (wb_addr),
      .wb_sel_i   (wb_sel),
      .wb_cyc_i   (wb_cyc),
      .wb_stb_i   (wb_stb),
      .wb_we_i    (wb_we),
      .wb_data_o  (wb_rdata),
      .wb_ack_o   (wb_ack),
      .wb_err_o   (wb_err),
      .wb_stall_o (wb_stall),
      .leds_o     (leds)
   );

   typedef struct {
      logic        we;
      logic [29:0] addr;
      logic [31:0] data;
      logic [3:0]  sel;
      logic        ack;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic add(input logic we, input logic [29:0] addr, input logic [31:0] data,
                      input logic [3:0] sel, input logic ack, input logic err,
                      input logic [31:0] rdata);
      vec_t v;
      v.we = we; v.addr = addr; v.data = data; v.sel = sel;
      v.ack = ack; v.err = err; v.rdata = rdata;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic we, input logic [29:0] addr, input logic [31:0] data,
                        input logic [3:0] sel);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
      wb_addr = addr; wb_wdata = data; wb_sel = sel;
   endtask

   task automatic idle();
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      wb_addr = '0; wb_wdata = '0; wb_sel = '0;
   endtask

   task automatic bus(input logic we, input logic [29:0] addr, input logic [31:0] data,
                      input logic [3:0] sel, output logic ack, output logic err,
                      output logic [31:0] rdata);
      @(negedge clk);
      drive(we, addr, data, sel);
      @(posedge clk); #1;
      ack = wb_ack; err = wb_err; rdata = wb_rdata;
      idle();
   endtask

   task automatic bus_write(input logic [29:0] addr, input logic [31:0] data,
                            input logic [3:0] sel, input string name);
      logic a, e;
      logic [31:0] d;
      bus(1'b1, addr, data, sel, a, e, d);
      check(name, {31'b0, a}, 32'd1);
   endtask

   // Enables the PWM with SYNC_CLR; counters start from zero at the write edge.
   task automatic start(input logic [1:0] ctrl);
      bus_write(30'd0, {29'b0, 1'b1, ctrl}, 4'h1, "start_ack");
   endtask

   task automatic cycle();
      @(posedge clk); #1;
   endtask

   // Channel 0 duty switches from old_d to new_d by a write applied at edge
   // E0+w+1; the new value must take effect exactly at the first period end.
   task automatic duty_change(input int old_d, input int new_d, input int w, input string name);
      int mism, hi0, hi1;
      logic exp;
      mism = 0; hi0 = 0; hi1 = 0;
      bus_write(30'd4, 32'(old_d), 4'hF, "dc_wr_old");
      start(2'b01);
      for (int t = 0; t < 2 * PERIOD; t++) begin
         if (t == w) begin
            @(negedge clk);
            drive(1'b1, 30'd4, 32'(new_d), 4'hF);
         end
         cycle();
         if (t == w) begin
            check({name, "_ack"}, {31'b0, wb_ack}, 32'd1);
            idle();
         end
         exp = (t % PERIOD) < ((t >= PERIOD) ? new_d : old_d);
         if (leds[0] !== exp) mism++;
         if (leds[0] === 1'b1) begin
            if (t < PERIOD) hi0++; else hi1++;
         end
      end
      check({name, "_mism"}, 32'(mism), 32'd0);
      check({name, "_hi_old"}, 32'(hi0), 32'(old_d));
      check({name, "_hi_new"}, 32'(hi1), 32'(new_d));
   endtask

   // Reference: with counters cleared at E0, the output seen after edge E0+t+1
   // reflects PWM count floor(t/(P+1)) mod 255 compared against each duty.
   function automatic logic [NL-1:0] model_leds(input int t, input int p, input logic inv);
      int c;
      c = (t / (p + 1)) % PERIOD;
      for (int i = 0; i < NL; i++) model_leds[i] = (c < duty_r[i]) ^ inv;
   endfunction

   initial begin
      #1ms;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic a, e;
      logic [31:0] d;
      int cnt, mism, p, ncyc;
      logic inv;

      idle();
      repeat (3) @(posedge clk);
      #1;
      check("rst_leds", {28'b0, leds}, 32'd0);
      check("rst_ack", {31'b0, wb_ack}, 32'd0);
      check("rst_err", {31'b0, wb_err}, 32'd0);
      check("rst_data", wb_rdata, 32'd0);
      check("rst_stall", {31'b0, wb_stall}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // ---------------- register-map vectors ----------------
      for (int i = 0; i < 3; i++) add(1'b0, 30'(i), 0, 4'hF, 1'b1, 1'b0, 32'h0);
      for (int i = 4; i < 4 + NL; i++) add(1'b0, 30'(i), 0, 4'hF, 1'b1, 1'b0, 32'h0);
      add(1'b0, 30'd3,      0, 4'hF, 1'b0, 1'b1, 32'h0);
      add(1'b0, 30'(4 + NL), 0, 4'hF, 1'b0, 1'b1, 32'h0);
      add(1'b1, 30'd1, 32'h1234_ABCD, 4'h1, 1'b1, 1'b0, 32'h0);
      add(1'b0, 30'd1, 0, 4'hF, 1'b1, 1'b0, 32'h0000_00CD);
      add(1'b1, 30'd1, 32'hFFFF_5600, 4'h2, 1'b1, 1'b0, 32'h0);
      add(1'b0, 30'd1, 0, 4'hF, 1'b1, 1'b0, 32'h0000_56CD);
      add(1'b1, 30'd5, 32'h0000_00AA, 4'h0, 1'b1, 1'b0, 32'h0);
      add(1'b0, 30'd5, 0, 4'hF, 1'b1, 1'b0, 32'h0);
      add(1'b1, 30'd5, 32'h0000_01FF, 4'hF, 1'b1, 1'b0, 32'h0);
      add(1'b0, 30'd5, 0, 4'hF, 1'b1, 1'b0, 32'h0000_00FF);
      add(1'b1, 30'd3, 32'h0000_0001, 4'hF, 1'b0, 1'b1, 32'h0);
      add(1'b0, 30'd3, 0, 4'hF, 1'b0, 1'b1, 32'h0);
      add(1'b1, 30'd2, 32'hAAFF_00FF, 4'hF, 1'b1, 1'b0, 32'h0);
      add(1'b0, 30'd2, 0, 4'hF, 1'b1, 1'b0, BLINK_RB);
      add(1'b1, 30'd2, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0);
      add(1'b1, 30'd0, 32'hFFFF_FFFF, 4'h0, 1'b1, 1'b0, 32'h0);
      add(1'b0, 30'd0, 0, 4'hF, 1'b1, 1'b0, 32'h0);
      add(1'b1, 30'd1, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0);
      add(1'b0, 30'd1, 0, 4'hF, 1'b1, 1'b0, 32'h0);
      add(1'b1, 30'd5, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0);

      foreach (vecs[k]) begin
         bus(vecs[k].we, vecs[k].addr, vecs[k].data, vecs[k].sel, a, e, d);
         check($sformatf("vec%0d_ack", k), {31'b0, a}, {31'b0, vecs[k].ack});
         check($sformatf("vec%0d_err", k), {31'b0, e}, {31'b0, vecs[k].err});
         if (!vecs[k].we) check($sformatf("vec%0d_data", k), d, vecs[k].rdata);
      end
      check("idle_leds", {28'b0, leds}, 32'd0);

      // ---------------- INVERT with EN=0 ----------------
      bus_write(30'd0, 32'h2, 4'h1, "inv_wr");
      cycle();
      check("inv_leds", {28'b0, leds}, 32'hF);
      bus_write(30'd0, 32'h0, 4'h1, "inv_off");
      cycle();
      check("inv_off_leds", {28'b0, leds}, 32'h0);

      // ---------------- duty 64 over a full period ----------------
      bus_write(30'd4, 32'd64, 4'hF, "d64_wr");
      start(2'b01);
      for (int w = 0; w < 2; w++) begin
         cnt = 0;
         for (int t = 0; t < PERIOD; t++) begin
            cycle();
            if (leds[0] === 1'b1) cnt++;
         end
         check($sformatf("d64_hi_win%0d", w), 32'(cnt), 32'd64);
      end

      // ---------------- duty extremes on channel 1 ----------------
      bus_write(30'd5, 32'd255, 4'hF, "d255_wr");
      start(2'b01);
      cnt = 0;
      for (int t = 0; t < 300; t++) begin
         cycle();
         if (leds[1] === 1'b1) cnt++;
      end
      check("d255_always_on", 32'(cnt), 32'd300);
      bus_write(30'd5, 32'd0, 4'hF, "d0_wr");
      start(2'b01);
      cnt = 0;
      for (int t = 0; t < 300; t++) begin
         cycle();
         if (leds[1] !== 1'b0) cnt++;
      end
      check("d0_always_off", 32'(cnt), 32'd0);

      // ---------------- duty updates: mid-period and on the boundary ----------------
      duty_change(64, 128, 20, "mid_period");
      duty_change(10, 200, PERIOD - 1, "at_period_end");

      // ---------------- SYNC_CLR while running ----------------
      bus_write(30'd4, 32'd100, 4'hF, "clr_duty");
      start(2'b01);
      repeat (150) cycle();
      check("clr_pre_low", {31'b0, leds[0]}, 32'd0);
      start(2'b01);
      mism = 0;
      for (int t = 0; t < 120; t++) begin
         cycle();
         if (leds[0] !== (t < 100)) mism++;
      end
      check("clr_restart", 32'(mism), 32'd0);

      // ---------------- PRESCALE shrunk below the running count ----------------
      bus_write(30'd4, 32'd1, 4'hF, "psc_duty");
      bus_write(30'd1, 32'd200, 4'hF, "psc_big");
      start(2'b01);
      repeat (50) cycle();
      bus_write(30'd1, 32'd10, 4'hF, "psc_small");
      cycle();
      check("psc_still_cnt0", {31'b0, leds[0]}, 32'd1);
      cycle();
      check("psc_ticked", {31'b0, leds[0]}, 32'd0);
      bus_write(30'd1, 32'd0, 4'hF, "psc_restore");

`ifdef LED_PWM_BLINK_EN
      // ---------------- blink: mask=1, B=1, full duty ----------------
      bus_write(30'd2, 32'h0001_0001, 4'hF, "blink_wr");
      bus_write(30'd4, 32'd255, 4'hF, "blink_duty");
      start(2'b01);
      mism = 0;
      for (int t = 0; t < 5 * PERIOD; t++) begin
         cycle();
         if (leds[0] !== (((t / PERIOD) / 2) % 2 == 0)) mism++;
      end
      check("blink_pattern", 32'(mism), 32'd0);
      bus_write(30'd2, 32'h0, 4'hF, "blink_off");
`endif

      // ---------------- randomized scenarios vs reference model ----------------
      for (int it = 0; it < 4; it++) begin
         p = $urandom_range(0, 3);
         inv = 1'($urandom_range(0, 1));
         for (int i = 0; i < NL; i++) begin
            case ($urandom_range(0, 5))
               0:       duty_r[i] = 0;
               1:       duty_r[i] = 255;
               default: duty_r[i] = $urandom_range(1, 254);
            endcase
            bus_write(30'(4 + i), 32'(duty_r[i]), 4'hF, "rnd_duty");
         end
         bus_write(30'd1, 32'(p), 4'hF, "rnd_psc");
         start({inv, 1'b1});
         ncyc = PERIOD * (p + 1) + 40;
         mism = 0;
         for (int t = 0; t < ncyc; t++) begin
            cycle();
            if (leds !== model_leds(t, p, inv)) begin
               mism++;
               if (mism <= 3)
                  check($sformatf("rnd%0d_t%0d", it, t), {28'b0, leds},
                        {28'b0, model_leds(t, p, inv)});
            end
         end
         check($sformatf("rnd%0d_mism", it), 32'(mism), 32'd0);
      end

      // ---------------- reset asserted mid-transfer ----------------
      @(negedge clk);
      drive(1'b0, 30'd1, 32'h0, 4'hF);
      @(posedge clk); #1;
      check("rstmid_ack_before", {31'b0, wb_ack}, 32'd1);
      reset = 1'b1;
      #1;
      check("rstmid_ack_dropped", {31'b0, wb_ack}, 32'd0);
      check("rstmid_leds", {28'b0, leds}, 32'd0);
      idle();
      @(negedge clk);
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
